// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: slot state encoding,
// default geometry and the select-width helper.
package stream_demux_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N_OUT = 4;

   // Width of the channel index; never narrower than one bit.
   function automatic int sel_w_f(input int n_out);
      int w;
      w = $clog2(n_out);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One valid/ready register stage. Holds a single payload word and reports
// EMPTY/FULL through out_valid. Loads when in_valid meets in_ready, drains
// when out_ready is seen while FULL; drain and load may happen together.
module stream_reg_slice
   import stream_demux_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   slot_state_e  state_r;
   logic [W-1:0] data_r;

   assign in_ready  = (state_r == EMPTY) || out_ready;
   assign out_valid = (state_r == FULL);
   assign out_data  = data_r;

   // Slot state machine: capture on load, release on drain, swap on both.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= EMPTY;
         data_r  <= '0;
      end else begin
         case (state_r)
            EMPTY: begin
               if (in_valid) begin
                  state_r <= FULL;
                  data_r  <= in_data;
               end else begin
                  state_r <= EMPTY;
               end
            end
            FULL: begin
               if (out_ready) begin
                  if (in_valid) begin
                     state_r <= FULL;
                     data_r  <= in_data;
                  end else begin
                     state_r <= EMPTY;
                  end
               end else begin
                  state_r <= FULL;
               end
            end
            default: begin
               state_r <= EMPTY;
               data_r  <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/stream_demux.sv
// Stream demultiplexer: routes each upstream beat to the channel named by
// up_sel through a one-entry output register. Beats addressed past the last
// channel are accepted, discarded and flagged on drop for one cycle.
// Build option STREAM_DEMUX_SKID_EN adds a skid entry so that up_ready comes
// from a flop instead of depending combinationally on down_ready.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N_OUT = DEF_N_OUT,
   localparam int SEL_W = sel_w_f(N_OUT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_data,
   input  logic [SEL_W-1:0] up_sel,
   output logic [N_OUT-1:0] down_valid,
   input  logic [N_OUT-1:0] down_ready,
   output logic [WIDTH-1:0] down_data,
   output logic             drop
);

   localparam int               PAY_W   = SEL_W + WIDTH;
   localparam logic [SEL_W:0]   N_OUT_C = (SEL_W + 1)'(N_OUT);

   logic             accept_s;
   logic             in_range_s;
   logic             main_in_valid_s;
   logic             main_in_ready_s;
   logic [PAY_W-1:0] main_in_data_s;
   logic             main_valid_s;
   logic             main_out_ready_s;
   logic [PAY_W-1:0] main_data_s;
   logic [SEL_W-1:0] main_sel_s;
   logic [N_OUT-1:0] down_valid_s;
   logic             drop_r;

   assign in_range_s = ({1'b0, up_sel} < N_OUT_C);
   assign main_sel_s = main_data_s[PAY_W-1:WIDTH];

`ifdef STREAM_DEMUX_SKID_EN
   logic             up_ready_r;
   logic             skid_in_valid_s;
   logic             skid_in_ready_s;
   logic             skid_full_s;
   logic [PAY_W-1:0] skid_data_s;
   logic             skid_full_next_s;

   assign up_ready = up_ready_r & ~rst;
   assign accept_s = up_valid & up_ready;

   // Older skid beat always goes first; new beats bypass only an empty skid.
   assign main_in_valid_s = skid_full_s | (accept_s & in_range_s);
   assign main_in_data_s  = skid_full_s ? skid_data_s : {up_sel, up_data};
   assign skid_in_valid_s = accept_s & in_range_s & ~main_in_ready_s & skid_in_ready_s;

   assign skid_full_next_s = skid_full_s ? ~main_in_ready_s : skid_in_valid_s;

   stream_reg_slice #(.W(PAY_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (skid_in_valid_s),
      .in_ready  (skid_in_ready_s),
      .in_data   ({up_sel, up_data}),
      .out_valid (skid_full_s),
      .out_ready (main_in_ready_s),
      .out_data  (skid_data_s)
   );

   // Registered upstream ready: low only while the skid entry will be occupied.
   always_ff @(posedge clk) begin
      if (rst) begin
         up_ready_r <= 1'b1;
      end else begin
         up_ready_r <= ~skid_full_next_s;
      end
   end
`else
   assign up_ready        = main_in_ready_s & ~rst;
   assign accept_s        = up_valid & up_ready;
   assign main_in_valid_s = accept_s & in_range_s;
   assign main_in_data_s  = {up_sel, up_data};
`endif

   stream_reg_slice #(.W(PAY_W)) u_main (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (main_in_valid_s),
      .in_ready  (main_in_ready_s),
      .in_data   (main_in_data_s),
      .out_valid (main_valid_s),
      .out_ready (main_out_ready_s),
      .out_data  (main_data_s)
   );

   // One-hot channel valid decoded from the held destination.
   always_comb begin
      down_valid_s = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (main_valid_s && (main_sel_s == SEL_W'(i))) begin
            down_valid_s[i] = 1'b1;
         end else begin
            down_valid_s[i] = 1'b0;
         end
      end
   end

   // Only the ready of the channel currently offered can drain the register.
   assign main_out_ready_s = |(down_ready & down_valid_s);

   // Drop pulse follows the cycle in which an out-of-range beat was accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_r <= 1'b0;
      end else begin
         drop_r <= accept_s & ~in_range_s;
      end
   end

   assign down_valid = down_valid_s;
   assign down_data  = main_data_s[WIDTH-1:0];
   assign drop       = drop_r;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance for the main
// scenarios and a 3-channel instance for the out-of-range drop path.
module tb_stream_demux;

`ifdef STREAM_DEMUX_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic       clk;
   logic       rst;

   logic       up_valid;
   logic       up_ready;
   logic [7:0] up_data;
   logic [1:0] up_sel;
   logic [3:0] down_valid;
   logic [3:0] down_ready;
   logic [7:0] down_data;
   logic       drop;

   logic       up_valid3;
   logic       up_ready3;
   logic [7:0] up_data3;
   logic [1:0] up_sel3;
   logic [2:0] down_valid3;
   logic [2:0] down_ready3;
   logic [7:0] down_data3;
   logic       drop3;

   int pass_cnt;
   int total_cnt;

   stream_demux #(.WIDTH(8), .N_OUT(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_sel     (up_sel),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .drop       (drop)
   );

   stream_demux #(.WIDTH(8), .N_OUT(3)) dut3 (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid3),
      .up_ready   (up_ready3),
      .up_data    (up_data3),
      .up_sel     (up_sel3),
      .down_valid (down_valid3),
      .down_ready (down_ready3),
      .down_data  (down_data3),
      .drop       (drop3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      logic [3:0] exp_dv;
      pass_cnt  = 0;
      total_cnt = 0;

      rst = 1'b1;
      up_valid = 1'b0; up_data = 8'h00; up_sel = 2'd0; down_ready = 4'b0000;
      up_valid3 = 1'b0; up_data3 = 8'h00; up_sel3 = 2'd0; down_ready3 = 3'b000;
      tick();
      tick();

      // Reset state
      check("rst_down_valid", 32'(down_valid), 32'h0);
      check("rst_down_data", 32'(down_data), 32'h0);
      check("rst_drop", 32'(drop), 32'h0);
      check("rst_up_ready", 32'(up_ready), 32'h0);
      check("rst_up_ready3", 32'(up_ready3), 32'h0);

      rst = 1'b0;
      #1;
      check("post_rst_up_ready", 32'(up_ready), 32'h1);

      // Single beat to channel 2
      up_sel = 2'd2; up_data = 8'hA5; up_valid = 1'b1; down_ready = 4'b0100;
      tick();
      up_valid = 1'b0; up_data = 8'hFF; up_sel = 2'd1;
      check("single_valid", 32'(down_valid), 32'h4);
      check("single_data", 32'(down_data), 32'hA5);
      check("single_drop", 32'(drop), 32'h0);
      tick();
      check("single_drained", 32'(down_valid), 32'h0);
      tick();
      check("idle_ignores_data", 32'(down_valid), 32'h0);

      // Backpressure on channel 1; readies of other channels must not drain it
      down_ready = 4'b1101; up_sel = 2'd1; up_data = 8'h3C; up_valid = 1'b1;
      #1;
      check("bp_first_ready", 32'(up_ready), 32'h1);
      tick();
      up_sel = 2'd3; up_data = 8'h77;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_valid", 32'(down_valid), 32'h2);
         check("bp_data", 32'(down_data), 32'h3C);
         check("bp_up_ready", 32'(up_ready), (SKID && i == 0) ? 32'h1 : 32'h0);
         tick();
         if (SKID && i == 0) begin
            up_valid = 1'b0;
         end
      end
      down_ready = 4'b0010;
      #1;
      check("bp_release_ready", 32'(up_ready), SKID ? 32'h0 : 32'h1);
      tick();
      up_valid = 1'b0;
      check("bp_second_valid", 32'(down_valid), 32'h8);
      check("bp_second_data", 32'(down_data), 32'h77);
      down_ready = 4'b1000;
      tick();
      check("bp_all_drained", 32'(down_valid), 32'h0);
      check("bp_ready_back", 32'(up_ready), 32'h1);

      // Back-to-back streaming, one beat per cycle
      down_ready = 4'b1111;
      for (int k = 0; k < 16; k++) begin
         up_valid = 1'b1;
         up_sel   = 2'(k % 4);
         up_data  = 8'(k);
         #1;
         check("stream_up_ready", 32'(up_ready), 32'h1);
         tick();
         exp_dv = 4'b0001 << (k % 4);
         check("stream_valid", 32'(down_valid), 32'(exp_dv));
         check("stream_data", 32'(down_data), 32'(k));
      end
      up_valid = 1'b0;
      check("stream_no_drop", 32'(drop), 32'h0);
      tick();
      check("stream_done", 32'(down_valid), 32'h0);

      // Reset while channel 0 holds a stalled beat
      down_ready = 4'b0000; up_sel = 2'd0; up_data = 8'h5A; up_valid = 1'b1;
      tick();
      up_valid = 1'b0;
      check("hold_valid", 32'(down_valid), 32'h1);
      check("hold_data", 32'(down_data), 32'h5A);
      rst = 1'b1;
      tick();
      check("midrst_valid", 32'(down_valid), 32'h0);
      check("midrst_data", 32'(down_data), 32'h0);
      check("midrst_up_ready", 32'(up_ready), 32'h0);
      rst = 1'b0;
      down_ready = 4'b1111;
      #1;
      check("midrst_release_ready", 32'(up_ready), 32'h1);
      tick();
      check("midrst_no_delivery1", 32'(down_valid), 32'h0);
      tick();
      check("midrst_no_delivery2", 32'(down_valid), 32'h0);

      // Out-of-range select on the 3-channel instance
      down_ready3 = 3'b111; up_sel3 = 2'd3; up_data3 = 8'hEE; up_valid3 = 1'b1;
      #1;
      check("oor_up_ready", 32'(up_ready3), 32'h1);
      tick();
      up_valid3 = 1'b0;
      check("oor_drop", 32'(drop3), 32'h1);
      check("oor_valid", 32'(down_valid3), 32'h0);
      tick();
      check("oor_drop_pulse_end", 32'(drop3), 32'h0);
      check("oor_valid_after", 32'(down_valid3), 32'h0);
      up_sel3 = 2'd2; up_data3 = 8'h11; up_valid3 = 1'b1;
      tick();
      up_valid3 = 1'b0;
      check("n3_valid", 32'(down_valid3), 32'h4);
      check("n3_data", 32'(down_data3), 32'h11);
      check("n3_no_drop", 32'(drop3), 32'h0);
      tick();
      check("n3_drained", 32'(down_valid3), 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
